mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported backing memory between the instruction-cache refill port (read-only) and the data port (data-cache refill reads and write-through stores).
- Sits between the pipeline's caches and main memory.
- The memory has a fixed, multi-cycle read latency, so the pipeline can hold a stall while a miss or store is in flight.
- Fixed priority favours data; a starvation guard ensures instruction fetch still makes progress.

Parameters:
- MEM_LATENCY, 2: cycles from the mem_en cycle to mem_rdata valid; legal values are 1 or more.
- ADDR_W, 8: word-address width of the backing memory.
- STARVE_LIMIT, 3: consecutive data wins over a waiting instruction request before the instruction port is forced to win.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_req  in  1  instruction refill request; held until i_ack.
- i_addr  in  32  byte address of the instruction word.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  out  32  returned instruction word; holds its value until the next i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; sampled at grant.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data; sampled at grant.
- d_ack  out  1  one-cycle completion pulse, for both reads and writes.
- d_rdata  out  32  read data, valid with d_ack on reads; unchanged by writes.
- mem_en  out  1  memory access strobe; exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  word address, equal to the selected addr[ADDR_W+1:2].
- mem_wdata  out  32  write data, valid with mem_en.
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after the mem_en cycle.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, starve_cnt 0. Reset asserted mid-transaction aborts it: no ack is issued and the late mem_rdata is discarded.
- State IDLE, with at least one request sampled:
  - Pick a winner and latch its addr, we and wdata.
  - Go to ISSUE.
  - No requests: stay in IDLE.
- State ISSUE:
  - mem_en=1; mem_we = latched we (always 0 for the instruction port); mem_addr and mem_wdata driven from the latched values.
  - Load the wait counter with MEM_LATENCY-1.
  - Go to WAIT, or go straight to RESP when MEM_LATENCY=1.
- State WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, register mem_rdata into the winner's rdata on the same edge and go to RESP.
- State RESP:
  - Pulse the winner's ack for one cycle.
  - Requests are ignored during this cycle, because the requester drops req on the edge after ack.
  - Go to IDLE.
- Latency: a request sampled at edge E0 sees ack asserted during cycle E0+1+MEM_LATENCY. Back-to-back transactions are separated by one IDLE cycle.
- Arbitration:
  - Only d_req: data wins. Only i_req: instruction wins.
  - Both requesting: data wins unless starve_cnt == STARVE_LIMIT, in which case instruction wins.
  - starve_cnt increments when data wins while i_req=1.
  - starve_cnt clears when instruction wins, or when i_req=0 at an arbitration.
  - starve_cnt saturates at STARVE_LIMIT.
- Address: bits [1:0] and bits above ADDR_W+1 are ignored (no alignment check, no wrap detection); the address wraps modulo 2^ADDR_W words.
- Request withdrawn before ack (protocol violation): the transaction still completes and the ack still pulses; no other state is corrupted.
- New requests arriving during ISSUE, WAIT or RESP are held by the requester and arbitrated at the next IDLE.
- Both ack outputs are never high in the same cycle. Writes assert no data-read side effects: d_rdata is unchanged by a write.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=3):
- Instruction read: i_req=1, i_addr=0x10, mem[4]=0xDEADBEEF sampled at edge 0 → mem_en=1 and mem_addr=4 in cycle 1; i_ack=1 and i_rdata=0xDEADBEEF in cycle 3; busy high in cycles 1-3.
- Data write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 → mem_en=1, mem_we=1, mem_addr=8, mem_wdata=0x12345678 in cycle 1; d_ack in cycle 3; d_rdata keeps its previous value.
- Simultaneous requests: i_req and d_req both held → data wins first (d_ack in cycle 3), instruction wins next (mem_en in cycle 5, i_ack in cycle 7).
- Starvation guard: d_req held continuously with a fresh request after each ack, and i_req held → exactly 3 data grants, then 1 instruction grant, then data resumes.
- Reset mid-transaction: reset pulsed during WAIT → all outputs 0 and state IDLE; no ack follows; a later request completes with normal latency.
- Address wrap and withdrawn request: i_addr=0x404 → mem_addr=1. A separate d_req dropped during WAIT → d_ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported backing memory between instruction refill and data ports
//
// Purpose: fixed-priority arbiter (data first) with a starvation guard for the
// instruction port. One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   i_req/i_addr        instruction refill request (read-only), byte address
//   i_ack/i_rdata       one-cycle completion pulse, returned word (held until next i_ack)
//   d_req/d_we/d_addr/d_wdata  data request, write flag, byte address, store data
//   d_ack/d_rdata       one-cycle completion pulse, read data (unchanged by writes)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  backing memory interface
//   busy                high in every state except IDLE
module mem_port_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int ADDR_W       = 8,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_ack,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
   localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_win_i;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [CNT_W-1:0]    r_cnt;
   logic [SC_W-1:0]     r_starve;
   logic [31:0]         r_i_rdata;
   logic [31:0]         r_d_rdata;
   logic                w_any_req;
   logic                w_pick_i;
   logic                w_capture;
   logic                w_unused;

   // Word address only: byte offset and bits above the memory size are dropped.
   assign w_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

   assign w_any_req = i_req | d_req;
   // Instruction wins when alone, or when data has already won STARVE_LIMIT times in a row.
   assign w_pick_i  = i_req & (~d_req | (r_starve == SC_W'(STARVE_LIMIT)));
   // Read data is registered on the edge that enters RESP.
   assign w_capture = ((r_state == S_WAIT) && (r_cnt == CNT_W'(1))) ||
                      ((r_state == S_ISSUE) && (MEM_LATENCY == 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_win_i   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_starve  <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_IDLE) && w_any_req) begin
            r_win_i <= w_pick_i;
            r_addr  <= w_pick_i ? i_addr[ADDR_W+1:2] : d_addr[ADDR_W+1:2];
            r_we    <= ~w_pick_i & d_we;
            r_wdata <= w_pick_i ? 32'd0 : d_wdata;
            if (w_pick_i || !i_req) begin
               r_starve <= '0;
            end else if (r_starve != SC_W'(STARVE_LIMIT)) begin
               r_starve <= r_starve + SC_W'(1);
            end
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= CNT_W'(MEM_LATENCY - 1);
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            if (r_win_i) begin
               r_i_rdata <= mem_rdata;
            end else if (!r_we) begin
               r_d_rdata <= mem_rdata;
            end
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      busy      = 1'b1;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      i_rdata   = r_i_rdata;
      d_rdata   = r_d_rdata;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_any_req) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_en = 1'b1;
            mem_we = r_we;
            w_next = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            i_ack  = r_win_i;
            d_ack  = ~r_win_i;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   logic [7:0]  wr_addr;
   logic [31:0] wr_data;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(8), .STARVE_LIMIT(3)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_fn(input logic [7:0] a);
      if (a == 8'd4) return 32'hDEADBEEF;
      return {24'hA5A5A5, a};
   endfunction

   // Backing memory: read data appears the cycle after mem_en and holds.
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) begin
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
         end else begin
            mem_rdata <= mem_fn(mem_addr);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] seq;
      int         ng;
      logic       both;
      logic       late_ack;

      reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_acks", {i_ack, d_ack}, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      reset = 1'b0;
      step();

      // Instruction read
      i_req = 1'b1; i_addr = 32'h10;
      step();
      chk("t1_c1_mem_en", mem_en, 1);
      chk("t1_c1_mem_we", mem_we, 0);
      chk("t1_c1_mem_addr", mem_addr, 4);
      chk("t1_c1_busy", busy, 1);
      step();
      chk("t1_c2_busy", busy, 1);
      chk("t1_c2_ack", {mem_en, i_ack}, 0);
      step();
      chk("t1_c3_i_ack", i_ack, 1);
      chk("t1_c3_d_ack", d_ack, 0);
      chk("t1_c3_i_rdata", i_rdata, 32'hDEADBEEF);
      chk("t1_c3_busy", busy, 1);
      i_req = 1'b0;
      step();
      chk("t1_c4_busy", busy, 0);
      chk("t1_c4_i_ack", i_ack, 0);
      chk("t1_c4_i_rdata_hold", i_rdata, 32'hDEADBEEF);

      // Data read to give d_rdata a known value
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
      step(); step(); step();
      chk("t2a_d_ack", d_ack, 1);
      chk("t2a_d_rdata", d_rdata, 32'hA5A5A50C);
      d_req = 1'b0;
      step();

      // Data write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
      step();
      chk("t2_c1_mem_en", mem_en, 1);
      chk("t2_c1_mem_we", mem_we, 1);
      chk("t2_c1_mem_addr", mem_addr, 8);
      chk("t2_c1_mem_wdata", mem_wdata, 32'h12345678);
      step();
      chk("t2_c2_d_ack", d_ack, 0);
      step();
      chk("t2_c3_d_ack", d_ack, 1);
      chk("t2_c3_d_rdata_kept", d_rdata, 32'hA5A5A50C);
      chk("t2_mem_written", {wr_addr, wr_data[23:0]}, {8'd8, 24'h345678});
      d_req = 1'b0; d_we = 1'b0;
      step();

      // Simultaneous requests: data first, then instruction
      i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h30;
      step();
      chk("t3_c1_mem_addr", mem_addr, 12);
      step(); step();
      chk("t3_c3_acks", {i_ack, d_ack}, 2'b01);
      d_req = 1'b0;
      step();
      chk("t3_c4_busy", busy, 0);
      step();
      chk("t3_c5_mem_en", mem_en, 1);
      chk("t3_c5_mem_addr", mem_addr, 4);
      step(); step();
      chk("t3_c7_acks", {i_ack, d_ack}, 2'b10);
      i_req = 1'b0;
      step();

      // Starvation guard: D D D I D
      i_addr = 32'h80; d_addr = 32'h40; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      seq = '0; ng = 0; both = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (i_ack && d_ack) both = 1'b1;
         if (i_ack) i_req = 1'b0;
         if (mem_en && ng < 5) begin
            seq[ng] = (mem_addr == 8'd32);
            ng++;
            if (ng == 5) d_req = 1'b0;
         end
         if (ng == 5 && !busy) break;
      end
      chk("t4_grants", ng, 5);
      chk("t4_order", seq, 5'b01000);
      chk("t4_both_acks", both, 0);
      chk("t4_idle", busy, 0);

      // Reset during WAIT
      i_req = 1'b1; i_addr = 32'h10; d_req = 1'b0;
      step();
      chk("t5_c1_mem_en", mem_en, 1);
      step();
      reset = 1'b1;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_outs", {mem_en, mem_we, i_ack, d_ack}, 0);
      chk("t5_rst_i_rdata", i_rdata, 0);
      chk("t5_rst_d_rdata", d_rdata, 0);
      i_req = 1'b0;
      step();
      reset = 1'b0;
      late_ack = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (i_ack || d_ack) late_ack = 1'b1;
      end
      chk("t5_no_late_ack", late_ack, 0);
      d_req = 1'b1; d_addr = 32'h30;
      step();
      chk("t5b_c1_mem_en", mem_en, 1);
      step();
      chk("t5b_c2_d_ack", d_ack, 0);
      step();
      chk("t5b_c3_d_ack", d_ack, 1);
      chk("t5b_c3_d_rdata", d_rdata, 32'hA5A5A50C);
      d_req = 1'b0;
      step();

      // Address wrap
      i_req = 1'b1; i_addr = 32'h404;
      step();
      chk("t6_mem_addr", mem_addr, 1);
      step(); step();
      chk("t6_i_ack", i_ack, 1);
      chk("t6_i_rdata", i_rdata, 32'hA5A5A501);
      i_req = 1'b0;
      step();

      // Data request withdrawn during WAIT
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
      step();
      chk("t7_c1_mem_en", mem_en, 1);
      step();
      d_req = 1'b0;
      step();
      chk("t7_c3_d_ack", d_ack, 1);
      chk("t7_c3_d_rdata", d_rdata, 32'hA5A5A502);
      step();
      chk("t7_c4_idle", {busy, d_ack}, 0);
      step();
      chk("t7_c5_idle", {busy, mem_en}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
